// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and producer latencies for the hazard scoreboard and the decoder
// that drives id_lat.
package hazard_pkg;

  localparam int NREGS_DEF = 32;
  localparam int LAT_W_DEF = 3;
  localparam int CNT_W_DEF = 16;

  typedef logic [$clog2(NREGS_DEF)-1:0] regbits_t;
  typedef logic [LAT_W_DEF-1:0]         lat_t;

  // Cycles after issue before the result can be forwarded.
  localparam lat_t LAT_ALU = lat_t'(0);
  localparam lat_t LAT_MEM = lat_t'(1);
  localparam lat_t LAT_MUL = lat_t'(4);

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard bus between the pipeline control (master) and the hazard
// scoreboard (slave).
interface hazard_if
  import hazard_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int LAT_W = LAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  localparam int REG_W = $clog2(NREGS);

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_wen;
  logic [REG_W-1:0] id_rd;
  logic [LAT_W-1:0] id_lat;
  logic             mem_wait;
  logic             branch_taken;
  logic             jump_taken;
  logic             freeze;
  logic             bubble;
  logic             flush;
  logic             busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wen, id_rd,
           id_lat, mem_wait, branch_taken, jump_taken,
    input  freeze, bubble, flush, busy, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wen, id_rd,
           id_lat, mem_wait, branch_taken, jump_taken,
    output freeze, bubble, flush, busy, stall_cycles
  );

endinterface

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard slot: remaining cycles until a pending register result can be
// forwarded. Load wins over decrement; hold freezes the slot during memory stalls.
module scoreboard_entry #(
  parameter int LAT_W = 3
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             hold,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (!hold) begin
      if (load) begin
        cnt <= load_val;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register latency scoreboard: RAW/WAW stall detection, flush priority and a
// saturating stall-cycle counter for the IF/ID and ID/EX latch controls.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int LAT_W = LAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic     CLK,
  input logic     nRST,
  hazard_if.slave hz
);
  localparam int REG_W = $clog2(NREGS);

  logic [LAT_W-1:0] cnt [NREGS];
  logic [CNT_W-1:0] stall_cnt;
  logic             raw;
  logic             waw;
  logic             hazard;
  logic             ctrl_xfer;
  logic             issue;
  logic             any_pending;

  // Register 0 is hard-wired, so it never gets a slot.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NREGS; r++) begin : g_entry
    scoreboard_entry #(.LAT_W(LAT_W)) u_entry (
      .CLK      (CLK),
      .nRST     (nRST),
      .hold     (hz.mem_wait),
      .load     (issue && hz.id_wen && (hz.id_rd == REG_W'(r))),
      .load_val (hz.id_lat),
      .cnt      (cnt[r])
    );
  end

  always_comb begin
    any_pending = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      any_pending = any_pending | (cnt[r] != '0);
    end
  end

  assign raw = (hz.id_uses_rs && (cnt[hz.id_rs] != '0)) ||
               (hz.id_uses_rt && (cnt[hz.id_rt] != '0));
  // An older long-latency write must land before a younger short one.
  assign waw = hz.id_wen && (hz.id_rd != '0) && (cnt[hz.id_rd] > hz.id_lat);

  assign hazard    = hz.id_valid && (raw || waw);
  assign ctrl_xfer = hz.branch_taken || hz.jump_taken;
  assign issue     = hz.id_valid && !hazard && !ctrl_xfer && !hz.mem_wait;

  // nRST gating keeps the latch controls quiet while the block is in reset.
  assign hz.flush        = nRST && ctrl_xfer;
  assign hz.freeze       = nRST && !ctrl_xfer && hazard;
  assign hz.bubble       = nRST && !ctrl_xfer && hazard;
  assign hz.busy         = nRST && any_pending;
  assign hz.stall_cycles = stall_cnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (hazard && !ctrl_xfer && !hz.mem_wait && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a remaining-cycles
// model; a second instance with a 4-bit stall counter exercises saturation.
module tb_hazard_scoreboard;

  localparam int NREGS = 32;
  localparam int LAT_W = 3;
  localparam int CNT_W = 16;
  localparam int SAT_W = 4;
  localparam int SAT_MAX = 15;

  logic CLK = 1'b0;
  logic nRST = 1'b0;

  always #5 CLK = ~CLK;

  hazard_if #(.NREGS(NREGS), .LAT_W(LAT_W), .CNT_W(CNT_W)) hif ();
  hazard_if #(.NREGS(NREGS), .LAT_W(LAT_W), .CNT_W(SAT_W)) sif ();

  assign sif.id_valid     = hif.id_valid;
  assign sif.id_rs        = hif.id_rs;
  assign sif.id_rt        = hif.id_rt;
  assign sif.id_uses_rs   = hif.id_uses_rs;
  assign sif.id_uses_rt   = hif.id_uses_rt;
  assign sif.id_wen       = hif.id_wen;
  assign sif.id_rd        = hif.id_rd;
  assign sif.id_lat       = hif.id_lat;
  assign sif.mem_wait     = hif.mem_wait;
  assign sif.branch_taken = hif.branch_taken;
  assign sif.jump_taken   = hif.jump_taken;

  hazard_scoreboard #(.NREGS(NREGS), .LAT_W(LAT_W), .CNT_W(CNT_W)) u_dut (
    .CLK  (CLK),
    .nRST (nRST),
    .hz   (hif)
  );

  hazard_scoreboard #(.NREGS(NREGS), .LAT_W(LAT_W), .CNT_W(SAT_W)) u_sat (
    .CLK  (CLK),
    .nRST (nRST),
    .hz   (sif)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: remaining cycles before each register's result is available.
  int remaining [NREGS];
  int model_stalls;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < NREGS; r++) remaining[r] = 0;
    model_stalls = 0;
  endfunction

  // One ID cycle: drive, check combinational outputs, advance the model at the edge.
  task automatic step(input bit v, input int rs, input int rt, input bit urs,
                      input bit urt, input bit wen, input int rd, input int lat,
                      input bit mw, input bit br, input bit jp);
    bit raw, waw, hz, xfer, pend, iss;
    hif.id_valid     = v;
    hif.id_rs        = 5'(rs);
    hif.id_rt        = 5'(rt);
    hif.id_uses_rs   = urs;
    hif.id_uses_rt   = urt;
    hif.id_wen       = wen;
    hif.id_rd        = 5'(rd);
    hif.id_lat       = 3'(lat);
    hif.mem_wait     = mw;
    hif.branch_taken = br;
    hif.jump_taken   = jp;
    #1;
    raw  = (urs && remaining[rs] > 0) || (urt && remaining[rt] > 0);
    waw  = wen && rd != 0 && remaining[rd] > lat;
    hz   = v && (raw || waw);
    xfer = br || jp;
    pend = 1'b0;
    for (int r = 0; r < NREGS; r++) if (remaining[r] > 0) pend = 1'b1;
    iss  = v && !hz && !xfer && !mw;
    check("flush",  int'(hif.flush),  int'(xfer));
    check("freeze", int'(hif.freeze), int'(hz && !xfer));
    check("bubble", int'(hif.bubble), int'(hz && !xfer));
    check("busy",   int'(hif.busy),   int'(pend));
    check("stall_cycles", int'(hif.stall_cycles), model_stalls);
    check("sat_stall_cycles", int'(sif.stall_cycles),
          (model_stalls > SAT_MAX) ? SAT_MAX : model_stalls);
    @(posedge CLK);
    if (!mw) begin
      for (int r = 0; r < NREGS; r++) if (remaining[r] > 0) remaining[r]--;
      if (iss && wen && rd != 0) remaining[rd] = lat;
      if (hz && !xfer) model_stalls++;
    end
    @(negedge CLK);
  endtask

  task automatic producer(input int rd, input int lat);
    step(1, 0, 0, 0, 0, 1, rd, lat, 0, 0, 0);
  endtask

  task automatic consumer(input int rs, input int rd, input int n);
    for (int i = 0; i < n; i++) step(1, rs, 4, 1, 1, 1, rd, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int base;

  initial begin
    model_reset();
    hif.id_valid = 0; hif.id_rs = '0; hif.id_rt = '0; hif.id_uses_rs = 0;
    hif.id_uses_rt = 0; hif.id_wen = 0; hif.id_rd = '0; hif.id_lat = '0;
    hif.mem_wait = 0; hif.branch_taken = 1; hif.jump_taken = 0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_flush", int'(hif.flush), 0);
    check("rst_busy",  int'(hif.busy), 0);
    check("rst_stall", int'(hif.stall_cycles), 0);
    @(negedge CLK);
    nRST = 1'b1;
    hif.branch_taken = 0;

    // Load-use: one stall, then issue.
    base = int'(hif.stall_cycles);
    producer(2, 1);
    step(1, 2, 4, 1, 1, 1, 3, 0, 0, 0, 0);
    step(1, 2, 4, 1, 1, 1, 3, 0, 0, 0, 0);
    check("load_use_stalls", int'(hif.stall_cycles) - base, 1);

    // Multiply latency 4 with two memory-wait cycles inside the stall window.
    base = int'(hif.stall_cycles);
    producer(5, 4);
    consumer(5, 8, 1);
    step(1, 5, 4, 1, 1, 1, 8, 0, 1, 0, 0);
    step(1, 5, 4, 1, 1, 1, 8, 0, 1, 0, 0);
    consumer(5, 8, 4);
    check("mult_mw_stalls", int'(hif.stall_cycles) - base, 4);
    check("mult_mw_busy", int'(hif.busy), 0);

    // WAW: short write to $6 waits for the pending multiply.
    producer(6, 4);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0);
    check("waw_busy", int'(hif.busy), 0);

    // Flush beats a live hazard; the stalled consumer never issues.
    producer(5, 4);
    consumer(5, 9, 1);
    step(1, 5, 4, 1, 1, 1, 9, 0, 0, 1, 0);
    step(1, 5, 4, 1, 1, 1, 9, 0, 0, 0, 1);
    idle(2);

    // Register 0 never becomes pending.
    producer(0, 1);
    consumer(0, 3, 1);
    check("r0_busy", int'(hif.busy), 0);

    // Asynchronous reset mid-stall.
    producer(7, 4);
    consumer(7, 3, 1);
    hif.branch_taken = 1;
    #2 nRST = 1'b0;
    #1;
    check("arst_busy",   int'(hif.busy), 0);
    check("arst_stall",  int'(hif.stall_cycles), 0);
    check("arst_flush",  int'(hif.flush), 0);
    check("arst_freeze", int'(hif.freeze), 0);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    hif.branch_taken = 0;

    // 21 hazard cycles: the narrow counter must stop at 15.
    for (int k = 0; k < 3; k++) begin
      producer(1, 7);
      consumer(1, 2, 8);
    end
    check("sat_value", int'(sif.stall_cycles), SAT_MAX);
    check("wide_value", int'(hif.stall_cycles), 21);
    idle(2);
    check("sat_hold", int'(sif.stall_cycles), SAT_MAX);

    // Random traffic on a handful of registers to keep hazards frequent.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 2) != 0,
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 6) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
